// File: rtl/axis_tx_arbiter.sv
// axis_tx_arbiter: packet-atomic 2:1 AXI-Stream arbiter feeding the TX FIFO.
// Port 0 carries Zynq data, port 1 carries locally generated info packets.
//
// Ports:
//   clk, rst           single clock, asynchronous active-high reset
//   s0_axis_*          Zynq stream slave (tdata/tlast/tvalid/tready)
//   s1_axis_*          info stream slave (tdata/tlast/tvalid/tready)
//   m_axis_*           merged stream master, registered (one-stage pipeline)
//   grant              one-hot current owner, 00 while arbitrating
//   pkt_cnt0/pkt_cnt1  completed packets per port, wrapping counters
//
// Parameters:
//   DATA_WIDTH     tdata width on all ports
//   PRIORITY_MODE  0 = round-robin, 1 = port 1 always wins arbitration
//   CNT_WIDTH      width of each packet counter

module axis_tx_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int PRIORITY_MODE = 0,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tlast,
    input  logic                  s0_axis_tvalid,
    output logic                  s0_axis_tready,

    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tlast,
    input  logic                  s1_axis_tvalid,
    output logic                  s1_axis_tready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,

    output logic [1:0]            grant,
    output logic [CNT_WIDTH-1:0]  pkt_cnt0,
    output logic [CNT_WIDTH-1:0]  pkt_cnt1
);

    // Encoding doubles as the one-hot grant vector, so grant comes
    // straight from the state flops.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    state_t state_q;
    state_t state_d;

    // 0: port 0 wins a tie, 1: port 1 wins a tie (round-robin only)
    logic   rr_pref_q;

    logic   out_free;
    logic   acc0;
    logic   acc1;
    logic   pick1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        // Port 1 takes the arbitration when it is the only requester,
        // when fixed priority is selected, or when it holds the tie.
        pick1   = s1_axis_tvalid &&
                  ((PRIORITY_MODE != 0) || !s0_axis_tvalid || rr_pref_q);
        case (state_q)
            IDLE: begin
                if (pick1) begin
                    state_d = GRANT1;
                end else if (s0_axis_tvalid) begin
                    state_d = GRANT0;
                end
            end
            GRANT0: begin
                if (acc0 && s0_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            GRANT1: begin
                if (acc1 && s1_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        // The output register can take a beat when empty or draining.
        out_free       = !m_axis_tvalid || m_axis_tready;
        s0_axis_tready = (state_q == GRANT0) && out_free;
        s1_axis_tready = (state_q == GRANT1) && out_free;
        acc0           = s0_axis_tvalid && s0_axis_tready;
        acc1           = s1_axis_tvalid && s1_axis_tready;
        grant          = state_q;
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (acc0) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s0_axis_tdata;
            m_axis_tlast  <= s0_axis_tlast;
        end else if (acc1) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s1_axis_tdata;
            m_axis_tlast  <= s1_axis_tlast;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pointer and packet counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_pref_q <= 1'b0;
            pkt_cnt0  <= '0;
            pkt_cnt1  <= '0;
        end else begin
            if (acc0 && s0_axis_tlast) begin
                rr_pref_q <= 1'b1;
                pkt_cnt0  <= pkt_cnt0 + CNT_WIDTH'(1);
            end
            if (acc1 && s1_axis_tlast) begin
                rr_pref_q <= 1'b0;
                pkt_cnt1  <= pkt_cnt1 + CNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Design invariants
    // ------------------------------------------------------------------
    a_grant_onehot: assert property (
        @(posedge clk) disable iff (rst) $onehot0(grant)
    );

    a_ready_exclusive: assert property (
        @(posedge clk) disable iff (rst)
        !(s0_axis_tready && s1_axis_tready)
    );

    a_hold_stable: assert property (
        @(posedge clk) disable iff (rst)
        (m_axis_tvalid && !m_axis_tready) |=>
        (m_axis_tvalid && $stable(m_axis_tdata) && $stable(m_axis_tlast))
    );

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// tb_axis_tx_arbiter: scoreboard bench for axis_tx_arbiter.
// Instance a is round-robin; instance b is fixed priority with 4-bit counters.

module tb_axis_tx_arbiter;

    typedef struct {
        logic [31:0] d;
        logic        l;
        int          gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          vectors = 0;
    int          errors = 0;
    exp_t        qa[$];
    exp_t        qb[$];

    // index 0/1: instance a ports 0/1, index 2/3: instance b ports 0/1
    logic [31:0] sd[4];
    logic        sl[4];
    logic        sv[4];

    logic        a_s0_rdy, a_s1_rdy, b_s0_rdy, b_s1_rdy;
    logic [31:0] a_m_data, b_m_data;
    logic        a_m_last, a_m_valid, b_m_last, b_m_valid;
    logic        a_m_ready, b_m_ready;
    logic [1:0]  a_grant, b_grant;
    logic [15:0] a_cnt0, a_cnt1;
    logic [3:0]  b_cnt0, b_cnt1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axis_tx_arbiter #(
        .DATA_WIDTH(32), .PRIORITY_MODE(0), .CNT_WIDTH(16)
    ) dut_a (
        .clk(clk), .rst(rst),
        .s0_axis_tdata(sd[0]), .s0_axis_tlast(sl[0]),
        .s0_axis_tvalid(sv[0]), .s0_axis_tready(a_s0_rdy),
        .s1_axis_tdata(sd[1]), .s1_axis_tlast(sl[1]),
        .s1_axis_tvalid(sv[1]), .s1_axis_tready(a_s1_rdy),
        .m_axis_tdata(a_m_data), .m_axis_tlast(a_m_last),
        .m_axis_tvalid(a_m_valid), .m_axis_tready(a_m_ready),
        .grant(a_grant), .pkt_cnt0(a_cnt0), .pkt_cnt1(a_cnt1)
    );

    axis_tx_arbiter #(
        .DATA_WIDTH(32), .PRIORITY_MODE(1), .CNT_WIDTH(4)
    ) dut_b (
        .clk(clk), .rst(rst),
        .s0_axis_tdata(sd[2]), .s0_axis_tlast(sl[2]),
        .s0_axis_tvalid(sv[2]), .s0_axis_tready(b_s0_rdy),
        .s1_axis_tdata(sd[3]), .s1_axis_tlast(sl[3]),
        .s1_axis_tvalid(sv[3]), .s1_axis_tready(b_s1_rdy),
        .m_axis_tdata(b_m_data), .m_axis_tlast(b_m_last),
        .m_axis_tvalid(b_m_valid), .m_axis_tready(b_m_ready),
        .grant(b_grant), .pkt_cnt0(b_cnt0), .pkt_cnt1(b_cnt1)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic rdy(int p);
        case (p)
            0:       return a_s0_rdy;
            1:       return a_s1_rdy;
            2:       return b_s0_rdy;
            default: return b_s1_rdy;
        endcase
    endfunction

    task automatic exp_a(logic [31:0] d, logic l, int gap);
        qa.push_back('{d, l, gap});
    endtask

    task automatic exp_b(logic [31:0] d, logic l, int gap);
        qb.push_back('{d, l, gap});
    endtask

    // Present one beat and hold it until the handshake completes.
    task automatic send_beat(int p, logic [31:0] d, logic l);
        logic ok = 1'b0;
        int   n  = 0;
        sd[p] = d;
        sl[p] = l;
        sv[p] = 1'b1;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = rdy(p);
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            vectors++;
            errors++;
            $display("FAIL accept_timeout: port %0d beat %0h not taken", p, d);
        end
    endtask

    task automatic send_pkt(int p, logic [31:0] base, int len, bit hold);
        for (int i = 0; i < len; i++) begin
            send_beat(p, base + 32'(i), (i == len - 1));
        end
        if (!hold) sv[p] = 1'b0;
    endtask

    task automatic mon(bit is_b);
        int   last_cyc = 0;
        exp_t e;
        logic [31:0] d;
        logic l;
        logic v;
        logic r;
        forever begin
            @(negedge clk);
            v = is_b ? b_m_valid : a_m_valid;
            r = is_b ? b_m_ready : a_m_ready;
            d = is_b ? b_m_data : a_m_data;
            l = is_b ? b_m_last : a_m_last;
            if (!rst && v && r) begin
                if ((is_b ? qb.size() : qa.size()) == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_beat: inst %0d data %0h, expected none",
                             is_b, d);
                end else begin
                    e = is_b ? qb.pop_front() : qa.pop_front();
                    chk(is_b ? "b_data" : "a_data", d, e.d);
                    chk(is_b ? "b_last" : "a_last", 32'(l), 32'(e.l));
                    if (e.gap != 0)
                        chk(is_b ? "b_gap" : "a_gap",
                            32'(cyc - last_cyc), 32'(e.gap));
                end
                last_cyc = cyc;
            end
        end
    endtask

    task automatic drain(bit is_b);
        int n = 0;
        while ((is_b ? qb.size() : qa.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(is_b ? "b_drain" : "a_drain",
            32'(is_b ? qb.size() : qa.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) sv[i] = 1'b0;
        a_m_ready = 1'b1;
        b_m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            sd[i] = '0;
            sl[i] = 1'b0;
        end
        fork
            mon(1'b0);
            mon(1'b1);
            begin
                #500000;
                $display("FAIL watchdog: run did not finish");
                $fatal(1);
            end
        join_none

        // reset then idle
        apply_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(a_m_valid), 0);
        chk("rst_data", a_m_data, 0);
        chk("rst_last", 32'(a_m_last), 0);
        chk("rst_grant", 32'(a_grant), 0);
        chk("rst_rdy0", 32'(a_s0_rdy), 0);
        chk("rst_rdy1", 32'(a_s1_rdy), 0);
        chk("rst_cnt0", 32'(a_cnt0), 0);
        chk("rst_cnt1", 32'(a_cnt1), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_valid", 32'(a_m_valid), 0);
        end
        chk("idle_grant", 32'(a_grant), 0);
        @(posedge clk);
        #1;

        // single source, 4-beat packet
        exp_a('hA0, 0, 0);
        exp_a('hA1, 0, 1);
        exp_a('hA2, 0, 1);
        exp_a('hA3, 1, 1);
        fork
            send_pkt(0, 'hA0, 4, 0);
            begin
                @(negedge clk);
                chk("t2_grant_arb", 32'(a_grant), 0);
                @(negedge clk);
                chk("t2_grant", 32'(a_grant), 'h1);
                chk("t2_valid_pre", 32'(a_m_valid), 0);
                @(negedge clk);
                chk("t2_valid_lat", 32'(a_m_valid), 1);
                chk("t2_data_lat", a_m_data, 'hA0);
            end
        join
        drain(1'b0);
        chk("t2_grant_end", 32'(a_grant), 0);
        chk("t2_cnt0", 32'(a_cnt0), 1);
        chk("t2_cnt1", 32'(a_cnt1), 0);

        // round-robin contention
        apply_reset();
        exp_a('h10, 0, 0); exp_a('h11, 0, 1); exp_a('h12, 1, 1);
        exp_a('h20, 0, 2); exp_a('h21, 0, 1); exp_a('h22, 1, 1);
        exp_a('h13, 0, 2); exp_a('h14, 0, 1); exp_a('h15, 1, 1);
        exp_a('h23, 0, 2); exp_a('h24, 0, 1); exp_a('h25, 1, 1);
        fork
            begin
                send_pkt(0, 'h10, 3, 1);
                send_pkt(0, 'h13, 3, 0);
            end
            begin
                send_pkt(1, 'h20, 3, 1);
                send_pkt(1, 'h23, 3, 0);
            end
        join
        drain(1'b0);
        chk("t3_cnt0", 32'(a_cnt0), 2);
        chk("t3_cnt1", 32'(a_cnt1), 2);
        chk("t3_grant", 32'(a_grant), 0);

        // backpressure mid-packet
        apply_reset();
        exp_a('h50, 0, 0);
        exp_a('h51, 0, 1);
        exp_a('h52, 0, 0);
        exp_a('h53, 1, 1);
        fork
            send_pkt(0, 'h50, 4, 0);
            begin
                for (int n = 0; n < 50; n++) begin
                    @(negedge clk);
                    if (a_m_valid && a_m_data == 'h51) break;
                end
                @(posedge clk);
                #1;
                a_m_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("t5_hold_valid", 32'(a_m_valid), 1);
                    chk("t5_hold_data", a_m_data, 'h52);
                    chk("t5_hold_last", 32'(a_m_last), 0);
                    chk("t5_hold_rdy", 32'(a_s0_rdy), 0);
                end
                @(posedge clk);
                #1;
                a_m_ready = 1'b1;
            end
        join
        drain(1'b0);
        chk("t5_cnt0", 32'(a_cnt0), 1);

        // fixed priority: port 1 arrives while port 0 is mid-packet
        exp_b('h40, 0, 0); exp_b('h41, 0, 1); exp_b('h42, 1, 1);
        exp_b('h70, 0, 2); exp_b('h71, 1, 1);
        exp_b('h43, 1, 2);
        fork
            begin
                send_pkt(2, 'h40, 3, 1);
                send_pkt(2, 'h43, 1, 0);
            end
            begin
                for (int n = 0; n < 50; n++) begin
                    @(negedge clk);
                    if (b_m_valid) break;
                end
                @(posedge clk);
                #1;
                fork
                    send_pkt(3, 'h70, 2, 0);
                    begin
                        @(negedge clk);
                        chk("t4_grant_hold", 32'(b_grant), 'h1);
                        chk("t4_rdy1_blocked", 32'(b_s1_rdy), 0);
                    end
                join
            end
        join
        drain(1'b1);
        chk("t4_cnt0", 32'(b_cnt0), 2);
        chk("t4_cnt1", 32'(b_cnt1), 1);

        // counter wrap on the 4-bit instance
        for (int i = 0; i < 14; i++) begin
            exp_b('h80 + 32'(i), 1, 0);
            send_pkt(3, 'h80 + 32'(i), 1, 0);
        end
        drain(1'b1);
        chk("wrap_full", 32'(b_cnt1), 'hF);
        exp_b('hEE, 1, 0);
        send_pkt(3, 'hEE, 1, 0);
        drain(1'b1);
        chk("wrap_zero", 32'(b_cnt1), 0);
        chk("wrap_cnt0", 32'(b_cnt0), 2);

        // reset after beat 2 of a 4-beat packet
        apply_reset();
        exp_a('h60, 0, 0);
        send_beat(0, 'h60, 0);
        send_beat(0, 'h61, 0);
        #1;
        rst = 1'b1;
        sv[0] = 1'b0;
        #1;
        chk("t6_valid", 32'(a_m_valid), 0);
        chk("t6_last", 32'(a_m_last), 0);
        chk("t6_grant", 32'(a_grant), 0);
        chk("t6_cnt0", 32'(a_cnt0), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_grant_after", 32'(a_grant), 0);
        chk("t6_cnt0_after", 32'(a_cnt0), 0);
        chk("t6_valid_after", 32'(a_m_valid), 0);
        chk("qa_empty", 32'(qa.size()), 0);
        chk("qb_empty", 32'(qb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/axis_tx_arbiter.md
Name: axis_tx_arbiter

Overview:
- Packet-atomic 2:1 AXI-Stream arbiter in front of the TX buffering FIFO.
- Shares one output stream between the Zynq data stream (port 0) and the locally generated info-packet stream (port 1).
- The grant is held from the first beat until the tlast beat, so packets from the two sources are never interleaved.
- Output is registered, giving a one-stage pipeline; per-port packet counters and the current grant are exported for status registers.

Parameters:
- DATA_WIDTH, 32, width of tdata on all ports.
- PRIORITY_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority to port 1 (info).
- CNT_WIDTH, 16, width of each packet counter.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- s0_axis_tdata  in  DATA_WIDTH  Zynq stream data.
- s0_axis_tlast  in  1  Zynq end of packet.
- s0_axis_tvalid  in  1  Zynq valid.
- s0_axis_tready  out  1  Zynq ready.
- s1_axis_tdata  in  DATA_WIDTH  info stream data.
- s1_axis_tlast  in  1  info end of packet.
- s1_axis_tvalid  in  1  info valid.
- s1_axis_tready  out  1  info ready.
- m_axis_tdata  out  DATA_WIDTH  merged data, to the TX FIFO.
- m_axis_tlast  out  1  merged end of packet.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tready  in  1  FIFO ready.
- grant  out  2  one-hot current owner; 00 in IDLE.
- pkt_cnt0  out  CNT_WIDTH  completed port-0 packets, wraps.
- pkt_cnt1  out  CNT_WIDTH  completed port-1 packets, wraps.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; grant = 00.
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0.
  - Both s*_tready = 0; both counters = 0; round-robin pointer = port 0 preferred.
- FSM states:
  - IDLE: if no s*_tvalid, remain in IDLE. Otherwise pick a winner:
    - PRIORITY_MODE=1: port 1 wins whenever s1_tvalid.
    - PRIORITY_MODE=0: if both are valid, the preferred port wins; otherwise the sole valid port wins.
    - Next state is GRANT0 or GRANT1.
    - No beat is accepted in IDLE (one-cycle arbitration bubble).
  - GRANTn: on an accepted beat with tlast=1, go to IDLE, set the round-robin preference to the other port, and increment pkt_cntn.
- Ready/accept rules:
  - sn_tready = (state==GRANTn) && (!m_axis_tvalid || m_axis_tready). This is combinational from registered state and m_axis_tready.
  - A beat is accepted when sn_tvalid && sn_tready. The accepted tdata/tlast are loaded into the output register and m_axis_tvalid=1 on the next edge.
  - Output register: if m_axis_tvalid && m_axis_tready with no new accept, m_axis_tvalid clears. Output data is held stable while m_axis_tvalid && !m_axis_tready.
- Latency and throughput: one clock from input accept to m_axis_tvalid. Throughput is 1 beat/clk within a packet; there is one idle clock between packets.
- A granted source dropping tvalid mid-packet: the grant is held indefinitely, with no timeout and no injection from the other port.
- Single-beat packet (tlast on the first beat): legal; the grant is released after that beat.
- Simultaneous requests in round-robin mode: strictly alternate packets while both are continuously valid.
- Counter wrap: all-ones + 1 -> 0, with no saturation and no flag.
- Reset mid-packet:
  - The partial packet is discarded; the output register is cleared without emitting tlast.
  - Upstream sources must restart their packets; the downstream FIFO is reset by the same rst.
- The non-granted port's tready is always 0.
- grant is registered and is one-hot whenever the state is GRANTn.

Test Plan:
1. Reset then idle: rst high for 3 clk, both tvalid=0 -> all outputs 0, grant=00, counters 0, no m_axis_tvalid for 20 clk.
2. Single source: port 0 sends a 4-beat packet (0xA0..0xA3, tlast on 0xA3) with m_axis_tready=1 -> grant=01 one clk after tvalid, outputs appear in order 1 clk after each accept, then grant=00 and pkt_cnt0=1.
3. Round-robin contention (PRIORITY_MODE=0): both ports continuously offer 3-beat packets (port 0 0x1x, port 1 0x2x) -> output order P0,P1,P0,P1 with no beat interleaving and one bubble between packets; after 4 packets pkt_cnt0=2, pkt_cnt1=2.
4. Fixed priority (PRIORITY_MODE=1): port 0 is mid-packet when port 1 raises tvalid -> port 0 completes uninterrupted, port 1 wins the next arbitration even though port 0 is still valid.
5. Backpressure: drop m_axis_tready for 5 clk mid-packet -> m_axis_tdata/tlast held stable, granted s_tready=0 after the register fills, no beat lost or duplicated; sequence is intact after tready returns.
6. Reset mid-packet plus wrap:
   - Assert rst after beat 2 of 4 -> m_axis_tvalid=0 immediately (async), grant=00, no count increment.
   - Separately, preload 0xFFFF port-1 completions -> the next completion gives pkt_cnt1=0.
